andr_rr_sched: RTL
==================

Name: andr_rr_sched

Overview:
- Round-robin scheduler that shares one 4-operand x WIDTH bitwise AND-reduction datapath among NREQ requesters.
- Each requester presents a 4-operand bundle plus a lane mask.
- The scheduler grants one requester per cycle and drives the shared AND-reduce lanes.
- The result is registered with the winner's ID on a valid/ready output port that supports backpressure. It sits between independent operand sources and a single consumer.

Parameters:
- WIDTH, 2, bits per operand and per result.
- NREQ, 4, number of requesters (2..16).
- IDW, max(1, clog2(NREQ)), width of the result ID field (derived; do not override).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- ASYNCRESETN  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  bit i: requester i holds a valid bundle.
- req_ready  out  NREQ  bit i: requester i's bundle is accepted this cycle; one-hot or zero.
- req_data  in  NREQ*4*WIDTH  requester i occupies bits [i*4*WIDTH +: 4*WIDTH]; operand k sits at offset k*WIDTH within that slice.
- req_mask  in  NREQ*4  requester i occupies bits [i*4 +: 4]; bit k=1 includes operand k.
- O  out  WIDTH  registered AND-reduction result.
- O_id  out  IDW  index of the requester that produced O.
- O_valid  out  1  O/O_id hold a result.
- O_ready  in  1  consumer accepts O this cycle.

Behaviour:
- Reset (ASYNCRESETN=0, takes effect immediately, independent of CLK):
  - O=0, O_id=0, O_valid=0.
  - Round-robin pointer ptr=0, meaning requester 0 has highest priority.
  - req_ready is driven 0 while reset is asserted.
- Datapath: for each bit b in 0..WIDTH-1, O_next[b] is the AND of operand_k[b] over k=0..3.
  - A masked-off operand (mask bit 0) contributes all-ones.
  - mask=0000 yields O_next = all-ones.
- Advance condition: adv = !O_valid | O_ready, combinational.
- Grant logic (combinational):
  - When adv=1, grant the first i with req_valid[i]=1, searching ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1 (mod NREQ).
  - req_ready = one-hot(grant), or 0 if adv=0 or no req_valid.
  - req_ready depends combinationally on req_valid and O_ready. Requesters must not make req_valid depend on req_ready.
- Transfer: requester i's bundle is consumed when req_valid[i] & req_ready[i] at a rising edge.
- On a consumed bundle from requester g:
  - O <= AND-reduce(bundle g), O_id <= g, O_valid <= 1.
  - ptr <= (g+1) mod NREQ, so the winner drops to lowest priority.
  - Latency is 1 cycle from acceptance to O_valid.
- Output handshake with no grant: if O_valid & O_ready and no bundle is consumed, then O_valid <= 0. O and O_id hold their last values.
- Simultaneous drain and fill: if O_valid & O_ready and a new grant occurs in the same cycle, O_valid stays 1 and O/O_id load the new result. Full throughput is 1 result per cycle.
- Backpressure: if O_valid & !O_ready:
  - O, O_id and O_valid hold.
  - All req_ready=0 and ptr holds.
- Idle: no req_valid means no grant and ptr holds.
- Fairness: with all NREQ requesters continuously valid and O_ready=1, grants cycle 0,1,...,NREQ-1,0,... Any continuously valid requester is served within NREQ grants.
- Input stability: a requester must hold req_data, req_mask and req_valid stable until accepted. Bundle content changing while valid and unaccepted is not checked; the value sampled at acceptance is used.
- Reset mid-operation: a pending output is discarded (O_valid=0) and ptr returns to 0. Outputs stay at their reset values until the first rising edge after ASYNCRESETN deasserts.

Test Plan:
- Reset and basic reduce: assert ASYNCRESETN=0 mid-run -> O_valid=0, O=0, O_id=0, req_ready=0 immediately. Then release reset, WIDTH=2; req 2 valid, data ops {3,3,1,3}, mask 1111 -> req_ready=0100 that cycle; next cycle O=01, O_id=2, O_valid=1.
- Masking: req 0 with ops {0,3,3,2}, mask 1110 -> O=10. Same ops with mask 0000 -> O=11.
- Round-robin: all 4 requesters valid continuously, O_ready=1 -> grant sequence 0,1,2,3,0 on consecutive cycles; O_id follows one cycle later; O_valid stays 1 throughout.
- Backpressure: O_valid=1, O_ready=0 for 3 cycles with req 1 and req 3 valid -> req_ready=0000, O/O_id unchanged. Then O_ready=1 -> the grant goes to the next index at or after ptr, and the new result appears the next cycle with no bubble.
- Drain without refill: O_valid=1, O_ready=1, no req_valid -> O_valid=0 next cycle, O/O_id held, ptr unchanged.
- Reset mid-operation: grant req 3 (ptr becomes 0) then req 0 (ptr becomes 1); pulse ASYNCRESETN low between edges while O_valid=1 -> O_valid drops immediately. After release, with req 0 and req 1 valid, req 0 wins, confirming ptr reset to 0.

Source files
------------

// File: rtl/andr_rr_sched.sv
// -----------------------------------------------------------------------------
// andr_rr_sched
//
// Round-robin scheduler that shares one 4-operand x WIDTH bitwise AND-reduce
// datapath among NREQ requesters. Each cycle, at most one requester is granted.
// Its masked bundle is reduced, and the result is registered with the winner's
// index behind a valid/ready output stage that supports backpressure.
//
// Ports:
//   CLK          clock, rising edge
//   ASYNCRESETN  asynchronous active-low reset
//   req_valid    [NREQ]          requester i holds a valid bundle
//   req_ready    [NREQ]          one-hot (or zero) acceptance, combinational
//   req_data     [NREQ*4*WIDTH]  requester i at [i*4*WIDTH +: 4*WIDTH],
//                                operand k at offset k*WIDTH in that slice
//   req_mask     [NREQ*4]        requester i at [i*4 +: 4]; bit k includes op k
//   O            [WIDTH]         registered AND-reduction result
//   O_id         [IDW]           index of the requester that produced O
//   O_valid                      O/O_id hold a result
//   O_ready                      consumer accepts O this cycle
// -----------------------------------------------------------------------------
module andr_rr_sched #(
    parameter int WIDTH = 2,
    parameter int NREQ  = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    CLK,
    input  logic                    ASYNCRESETN,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*4*WIDTH-1:0] req_data,
    input  logic [NREQ*4-1:0]       req_mask,
    output logic [WIDTH-1:0]        O,
    output logic [IDW-1:0]          O_id,
    output logic                    O_valid,
    input  logic                    O_ready
);

    logic             adv;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   ptr;
    logic             fire;
    logic [4*WIDTH-1:0] sel_data;
    logic [3:0]       sel_mask;
    logic [WIDTH-1:0] o_next;

    // The output register can take a new result when empty or being drained.
    assign adv = !O_valid || O_ready;

    // Rotating priority search starting at ptr.
    // NOTE: every variable written in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(idx);
            end
        end
    end

    // Gated by reset so no bundle appears accepted while the block is held.
    assign fire      = adv && grant_found && ASYNCRESETN;
    assign req_ready = fire ? (NREQ'(1) << grant_idx) : '0;

    // Shared datapath: select the winner's bundle, masked operands read as ones.
    assign sel_data = req_data[int'(grant_idx)*4*WIDTH +: 4*WIDTH];
    assign sel_mask = req_mask[int'(grant_idx)*4 +: 4];

    always_comb begin
        o_next = '1;
        for (int k = 0; k < 4; k++) begin
            if (sel_mask[k]) begin
                o_next = o_next & sel_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            O       <= '0;
            O_id    <= '0;
            O_valid <= 1'b0;
            ptr     <= '0;
        end else if (fire) begin
            O       <= o_next;
            O_id    <= grant_idx;
            O_valid <= 1'b1;
            // Winner drops to lowest priority.
            ptr     <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end else if (O_ready) begin
            // Drained with nothing to refill; O/O_id keep their last values.
            O_valid <= 1'b0;
        end
    end

endmodule
